thor2024_rt_decode_stage: RTL and testbench

//  Parametrised N-lane target-register (Rt) decode pipeline stage between fetch/align and rename.

---
 rtl/thor2024_rt_decode_stage.sv | 191 +++++++++++++++++++
 tb/tb_thor2024_rt_decode_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/thor2024_rt_decode_stage.sv
// Thor2024 target-register (Rt) decode stage: N-lane decode, output register
// plus one skid entry, and a busy scoreboard of pending destinations.
package thor2024_rt_pkg;
  typedef logic [39:0] instruction_t;
endpackage

module thor2024_rt_decode_stage
  import thor2024_rt_pkg::*;
#(
  parameter int unsigned LANES     = 2,
  parameter int unsigned NREGS     = 64,
  parameter int unsigned WB_PORTS  = 2,
  parameter int unsigned STALL_WAW = 1,
  localparam int unsigned REGW     = $clog2(NREGS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  instruction_t [LANES-1:0]           in_instr,
  input  logic [LANES-1:0]                   in_lane_valid,
  output logic                               out_valid,
  input  logic                               out_ready,
  output instruction_t [LANES-1:0]           out_instr,
  output logic [LANES-1:0]                   out_lane_valid,
  output logic [LANES-1:0][REGW-1:0]         out_rt,
  output logic [LANES-1:0]                   out_rt_we,
  output logic [LANES-1:0]                   out_waw_intra,
  input  logic [WB_PORTS-1:0]                wb_valid,
  input  logic [WB_PORTS-1:0][REGW-1:0]      wb_rt,
  output logic [NREGS-1:0]                   busy
);

  // Major opcodes (ir[6:0]); Rt field is ir[12:7], R2 function is ir[39:33].
  localparam logic [6:0] OP_R2    = 7'd2;
  localparam logic [6:0] OP_ADDI  = 7'd4;
  localparam logic [6:0] OP_SLTI  = 7'd11;
  localparam logic [6:0] OP_SHIFT = 7'd12;
  localparam logic [6:0] OP_CSR   = 7'd13;
  localparam logic [6:0] OP_MOV   = 7'd14;
  localparam logic [6:0] OP_FLT2  = 7'd16;
  localparam logic [6:0] OP_FLT3  = 7'd17;
  localparam logic [6:0] OP_BSR   = 7'd32;
  localparam logic [6:0] OP_JSR   = 7'd33;
  localparam logic [6:0] OP_RTD   = 7'd34;
  localparam logic [6:0] OP_DBRA  = 7'd35;
  localparam logic [6:0] OP_BCC0  = 7'd40;
  localparam logic [6:0] OP_BCC7  = 7'd47;
  localparam logic [6:0] OP_LDB   = 7'd64;
  localparam logic [6:0] OP_LDO   = 7'd70;

  function automatic logic [REGW-1:0] decode_rt(input instruction_t ir);
    logic [6:0] op;
    logic [6:0] func;
    logic [5:0] rt6;
    logic [5:0] r;
    op   = ir[6:0];
    func = ir[39:33];
    rt6  = ir[12:7];
    r    = '0;
    if (op == OP_R2) begin
      // arithmetic 4..8, logic 9..14, set 16..23
      if (func inside {[7'd4:7'd14], [7'd16:7'd23]}) r = rt6;
    end else if (op inside {[OP_ADDI:OP_SLTI], OP_SHIFT, OP_CSR, OP_MOV,
                            OP_FLT2, OP_FLT3, [OP_LDB:OP_LDO]}) begin
      r = rt6;
    end else if (op == OP_BSR || op == OP_JSR) begin
      r = 6'd56 + {4'd0, ir[8:7]};
    end else if (op == OP_RTD) begin
      r = 6'd62;
    end else if (op inside {[OP_BCC0:OP_BCC7]}) begin
      r = 6'd56 + {5'd0, ir[7]};
    end else if (op == OP_DBRA) begin
      r = 6'd55;
    end
    return REGW'(r);
  endfunction

  logic                         out_full_q, out_full_d;
  instruction_t [LANES-1:0]     out_instr_q, out_instr_d;
  logic [LANES-1:0]             out_lane_valid_q, out_lane_valid_d;
  logic [LANES-1:0][REGW-1:0]   out_rt_q, out_rt_d;
  logic                         skid_full_q, skid_full_d;
  instruction_t [LANES-1:0]     skid_instr_q, skid_instr_d;
  logic [LANES-1:0]             skid_lane_valid_q, skid_lane_valid_d;
  logic [NREGS-1:0]             busy_q, busy_d;
  logic                         in_ready_q, in_ready_d;

  logic [LANES-1:0]             rt_busy_lane;
  logic                         stall, fire, accept;

  // Lane-level status derived from the registered output group and scoreboard
  always_comb begin
    out_rt_we     = '0;
    out_waw_intra = '0;
    rt_busy_lane  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      out_rt_we[i]    = out_lane_valid_q[i] && (out_rt_q[i] != '0);
      rt_busy_lane[i] = busy_q[out_rt_q[i]];
    end
    for (int unsigned i = 0; i < LANES; i++)
      for (int unsigned j = i + 1; j < LANES; j++)
        if (out_rt_we[i] && out_rt_we[j] && out_rt_q[j] == out_rt_q[i])
          out_waw_intra[i] = 1'b1;
    stall     = (STALL_WAW != 0) && |(out_rt_we & rt_busy_lane);
    out_valid = out_full_q && !stall;
    fire      = out_valid && out_ready;
    accept    = in_valid && in_ready_q;
  end

  // Buffer movement and scoreboard update
  always_comb begin
    out_full_d        = out_full_q;
    out_instr_d       = out_instr_q;
    out_lane_valid_d  = out_lane_valid_q;
    out_rt_d          = out_rt_q;
    skid_full_d       = skid_full_q;
    skid_instr_d      = skid_instr_q;
    skid_lane_valid_d = skid_lane_valid_q;
    busy_d            = busy_q;
    if (flush) begin
      out_full_d       = 1'b0;
      out_lane_valid_d = '0;
      skid_full_d      = 1'b0;
      busy_d           = '0;
    end else begin
      // in_ready is !skid_full, so an accept never coincides with a full skid
      if (!out_full_q || fire) begin
        if (skid_full_q) begin
          out_full_d       = 1'b1;
          out_instr_d      = skid_instr_q;
          out_lane_valid_d = skid_lane_valid_q;
          for (int unsigned i = 0; i < LANES; i++) out_rt_d[i] = decode_rt(skid_instr_q[i]);
          skid_full_d      = 1'b0;
        end else if (accept) begin
          out_full_d       = 1'b1;
          out_instr_d      = in_instr;
          out_lane_valid_d = in_lane_valid;
          for (int unsigned i = 0; i < LANES; i++) out_rt_d[i] = decode_rt(in_instr[i]);
        end else begin
          out_full_d = 1'b0;
        end
      end else if (accept) begin
        skid_full_d       = 1'b1;
        skid_instr_d      = in_instr;
        skid_lane_valid_d = in_lane_valid;
      end
      // clears first so a same-cycle set wins
      for (int unsigned p = 0; p < WB_PORTS; p++)
        if (wb_valid[p]) busy_d[wb_rt[p]] = 1'b0;
      if (fire)
        for (int unsigned i = 0; i < LANES; i++)
          if (out_rt_we[i]) busy_d[out_rt_q[i]] = 1'b1;
      busy_d[0] = 1'b0;
    end
    in_ready_d = !skid_full_d;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_full_q        <= 1'b0;
      out_instr_q       <= '0;
      out_lane_valid_q  <= '0;
      out_rt_q          <= '0;
      skid_full_q       <= 1'b0;
      skid_instr_q      <= '0;
      skid_lane_valid_q <= '0;
      busy_q            <= '0;
      in_ready_q        <= 1'b1;
    end else begin
      out_full_q        <= out_full_d;
      out_instr_q       <= out_instr_d;
      out_lane_valid_q  <= out_lane_valid_d;
      out_rt_q          <= out_rt_d;
      skid_full_q       <= skid_full_d;
      skid_instr_q      <= skid_instr_d;
      skid_lane_valid_q <= skid_lane_valid_d;
      busy_q            <= busy_d;
      in_ready_q        <= in_ready_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_instr      = out_instr_q;
  assign out_lane_valid = out_lane_valid_q;
  assign out_rt         = out_rt_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_thor2024_rt_decode_stage.sv
// Directed bench for thor2024_rt_decode_stage (LANES=2, NREGS=64, STALL_WAW=1).
module tb_thor2024_rt_decode_stage;
  import thor2024_rt_pkg::*;

  localparam logic [6:0] OP_R2   = 7'd2;
  localparam logic [6:0] OP_ADDI = 7'd4;
  localparam logic [6:0] OP_MOV  = 7'd14;
  localparam logic [6:0] OP_BSR  = 7'd32;
  localparam logic [6:0] OP_RTD  = 7'd34;
  localparam logic [6:0] OP_DBRA = 7'd35;
  localparam logic [6:0] OP_BEQ  = 7'd40;
  localparam logic [6:0] OP_LDB  = 7'd64;
  localparam logic [6:0] OP_LDO  = 7'd70;
  localparam logic [6:0] OP_STB  = 7'd72;

  logic                  clk = 1'b0;
  logic                  rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  instruction_t [1:0]    in_instr, out_instr;
  logic [1:0]            in_lane_valid, out_lane_valid, out_rt_we, out_waw_intra;
  logic [1:0][5:0]       out_rt;
  logic [1:0]            wb_valid;
  logic [1:0][5:0]       wb_rt;
  logic [63:0]           busy;
  int                    checks = 0;
  int                    errors = 0;
  logic [63:0]           exp_busy;

  always #5 clk = ~clk;

  thor2024_rt_decode_stage #(.LANES(2), .NREGS(64), .WB_PORTS(2), .STALL_WAW(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_lane_valid(in_lane_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_lane_valid(out_lane_valid), .out_rt(out_rt), .out_rt_we(out_rt_we),
    .out_waw_intra(out_waw_intra), .wb_valid(wb_valid), .wb_rt(wb_rt), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instruction_t mk(input logic [6:0] op, input logic [5:0] rt, input logic [6:0] func);
    return {func, 20'd0, rt, op};
  endfunction

  function automatic logic [63:0] bm(input int r);
    return 64'd1 << r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input instruction_t l0, input instruction_t l1, input logic [1:0] lv);
    in_valid      = 1'b1;
    in_instr[0]   = l0;
    in_instr[1]   = l1;
    in_lane_valid = lv;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_lane_valid = '0; wb_valid = '0; wb_rt = '0;
    #2 rst_n = 1'b0;
    step(); step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 64'd0);
    chk("rst_out_rt", {out_rt, out_rt_we, out_lane_valid, out_waw_intra}, 18'd0);
    rst_n = 1'b1;
    step();

    // ADDI r5 / LDO r9
    out_ready = 1'b1;
    send(mk(OP_ADDI, 6'd5, 7'd0), mk(OP_LDO, 6'd9, 7'd0), 2'b11);
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_out_rt", out_rt, {6'd9, 6'd5});
    chk("t1_out_rt_we", out_rt_we, 2'b11);
    chk("t1_out_instr", out_instr, {mk(OP_LDO, 6'd9, 7'd0), mk(OP_ADDI, 6'd5, 7'd0)});
    step();
    exp_busy = bm(5) | bm(9);
    chk("t1_busy", busy, exp_busy);
    chk("t1_drained", out_valid, 1'b0);

    // WAW stall on busy r5; invalid lane r3 must not touch the scoreboard
    send(mk(OP_ADDI, 6'd5, 7'd0), mk(OP_ADDI, 6'd3, 7'd0), 2'b01);
    step();
    in_valid = 1'b0;
    chk("t3_stall", out_valid, 1'b0);
    chk("t3_rt_we", out_rt_we, 2'b01);
    step();
    chk("t3_stall_held", out_valid, 1'b0);
    wb_valid = 2'b01; wb_rt[0] = 6'd5;
    step();
    wb_valid = 2'b00;
    chk("t3_busy_cleared", busy, bm(9));
    chk("t3_unstall", out_valid, 1'b1);
    step();
    chk("t3_busy_reset", busy, exp_busy);

    // Fire setting r12 while wb clears r12 and r9
    send(mk(OP_ADDI, 6'd12, 7'd0), '0, 2'b01);
    step();
    in_valid = 1'b0;
    chk("t5_out_valid", out_valid, 1'b1);
    wb_valid = 2'b11; wb_rt[0] = 6'd9; wb_rt[1] = 6'd12;
    step();
    wb_valid = 2'b00;
    exp_busy = bm(5) | bm(12);
    chk("t5_set_wins", busy, exp_busy);

    // BSR ir[8:7]=2 / BEQ ir[7]=1
    send(mk(OP_BSR, 6'd2, 7'd0), mk(OP_BEQ, 6'd1, 7'd0), 2'b11);
    step();
    in_valid = 1'b0;
    chk("t4_branch_rt", out_rt, {6'd57, 6'd58});
    chk("t4_branch_valid", out_valid, 1'b1);
    step();
    send(mk(OP_MOV, 6'd7, 7'd0), mk(OP_MOV, 6'd7, 7'd0), 2'b11);
    step();
    in_valid = 1'b0;
    chk("t4_waw_intra", out_waw_intra, 2'b01);
    chk("t4_no_stall", out_valid, 1'b1);
    step();
    exp_busy = exp_busy | bm(7) | bm(57) | bm(58);
    chk("t4_busy", busy, exp_busy);

    // RTD / DBRA
    send(mk(OP_RTD, 6'd3, 7'd0), mk(OP_DBRA, 6'd3, 7'd0), 2'b11);
    step();
    in_valid = 1'b0;
    chk("dec_rtd_dbra", out_rt, {6'd55, 6'd62});
    step();
    // R2 ADD r20 / R2 unlisted func
    send(mk(OP_R2, 6'd20, 7'd4), mk(OP_R2, 6'd21, 7'd40), 2'b11);
    step();
    in_valid = 1'b0;
    chk("dec_r2", out_rt, {6'd0, 6'd20});
    chk("dec_r2_we", out_rt_we, 2'b01);
    step();
    // store / LDB r23
    send(mk(OP_STB, 6'd22, 7'd0), mk(OP_LDB, 6'd23, 7'd0), 2'b11);
    step();
    in_valid = 1'b0;
    chk("dec_st_ld", out_rt, {6'd23, 6'd0});
    step();
    exp_busy = exp_busy | bm(20) | bm(23) | bm(55) | bm(62);
    chk("dec_busy", busy, exp_busy);

    // Back-pressure: three groups back-to-back with out_ready low
    out_ready = 1'b0;
    send(mk(OP_ADDI, 6'd40, 7'd0), '0, 2'b01);
    step();
    chk("t2_ready_a", in_ready, 1'b1);
    chk("t2_out_a", out_rt, {6'd0, 6'd40});
    send(mk(OP_ADDI, 6'd41, 7'd0), '0, 2'b01);
    step();
    chk("t2_ready_full", in_ready, 1'b0);
    send(mk(OP_ADDI, 6'd42, 7'd0), '0, 2'b01);
    step();
    chk("t2_ready_held", in_ready, 1'b0);
    chk("t2_stable", out_rt, {6'd0, 6'd40});
    chk("t2_valid_held", out_valid, 1'b1);
    out_ready = 1'b1;
    step();
    chk("t2_out_b", out_rt, {6'd0, 6'd41});
    chk("t2_ready_back", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t2_out_c", out_rt, {6'd0, 6'd42});
    chk("t2_valid_c", out_valid, 1'b1);
    step();
    chk("t2_no_dup", out_valid, 1'b0);
    exp_busy = exp_busy | bm(40) | bm(41) | bm(42);
    chk("t2_busy", busy, exp_busy);

    // Flush with both entries full
    out_ready = 1'b0;
    send(mk(OP_ADDI, 6'd44, 7'd0), '0, 2'b01);
    step();
    send(mk(OP_ADDI, 6'd45, 7'd0), '0, 2'b01);
    step();
    in_valid = 1'b0;
    chk("t6_full", in_ready, 1'b0);
    flush = 1'b1;
    send(mk(OP_ADDI, 6'd46, 7'd0), '0, 2'b01);
    wb_valid = 2'b01; wb_rt[0] = 6'd5;
    step();
    flush = 1'b0; in_valid = 1'b0; wb_valid = 2'b00;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_busy", busy, 64'd0);
    out_ready = 1'b1;
    step();
    chk("t6_dropped", out_valid, 1'b0);

    // Asynchronous reset mid-transfer
    send(mk(OP_ADDI, 6'd3, 7'd0), '0, 2'b01);
    step();
    in_valid = 1'b0;
    step();
    chk("ar_busy_pre", busy, bm(3));
    out_ready = 1'b0;
    send(mk(OP_ADDI, 6'd4, 7'd0), '0, 2'b01);
    step();
    in_valid = 1'b0;
    chk("ar_valid_pre", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_in_ready", in_ready, 1'b1);
    chk("ar_busy", busy, 64'd0);
    chk("ar_outs", {out_rt, out_rt_we, out_lane_valid, out_waw_intra}, 18'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
